rayleigh_quotient: RTL
======================

RAYLEIGH_QUOTIENT -- requirements
Module: rayleigh_quotient

Interface
REQ-001 Parameter SIZE_N, default 8: matrix/vector dimension (>=2).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low (asserted when 0).
REQ-004 start  input  1  request; driven by the upstream eigenloop finished flag, held high while its vector is valid.
REQ-005 timed_matrix  input  double[SIZE_N][SIZE_N]  matrix A, same matrix the eigenloop iterated on.
REQ-006 vector_in  input  double[SIZE_N][1]  converged eigenvector v from the eigenloop vector_out.
REQ-007 eigenvalue  output  double  registered Rayleigh quotient lambda = (v^T A v)/(v^T v).
REQ-008 zero_vec  output  1  registered; high when v^T v is exactly zero.
REQ-009 f  output  1  finished; high only in FINISHED_RQ.

Function
REQ-010 The FSM SHALL have states IDLE_RQ, MATVEC_RQ, DOT_RQ, DIVIDE_RQ, FINISHED_RQ; any other encoding SHALL go to IDLE_RQ.
REQ-011 IDLE_RQ: start=1 at an edge SHALL latch A and v into internal registers, clear w[], num, den, zero the indices, and go to MATVEC_RQ; otherwise stay.
REQ-012 Inputs SHALL NOT be sampled after the latch edge; changes to timed_matrix/vector_in mid-operation have no effect.
REQ-013 MATVEC_RQ: each cycle one MAC w[i] += A[i][j]*v[j], j inner index 0..SIZE_N-1, i outer; exactly SIZE_N*SIZE_N cycles, then DOT_RQ.
REQ-014 DOT_RQ: each cycle num += v[i]*w[i] and den += v[i]*v[i] in parallel, i = 0..SIZE_N-1; exactly SIZE_N cycles, then DIVIDE_RQ.
REQ-015 DIVIDE_RQ (1 cycle): if den exponent and mantissa are both zero, eigenvalue <= +0.0 and zero_vec <= 1; else eigenvalue <= num/den and zero_vec <= 0; then FINISHED_RQ.
REQ-016 Latency: with start first sampled high at edge 0, f SHALL be high after edge SIZE_N*SIZE_N+SIZE_N+1 (73 for SIZE_N=8).
REQ-017 FINISHED_RQ: f=1; eigenvalue and zero_vec held stable; stay while start=1; start=0 SHALL return to IDLE_RQ at the next edge, f low after it.
REQ-018 eigenvalue and zero_vec SHALL hold their last result in IDLE_RQ until the next DIVIDE_RQ overwrites them.
REQ-019 start dropping during MATVEC_RQ/DOT_RQ/DIVIDE_RQ SHALL be ignored; the computation completes.
REQ-020 All arithmetic SHALL be IEEE-754 double via the fp_double package types and operations; no width reduction, accumulation in declared index order.

Reset
REQ-021 rst=0 SHALL immediately force state IDLE_RQ, f=0, eigenvalue=+0.0, zero_vec=0, indices=0, w[]/num/den=0, regardless of clock.
REQ-022 Reset asserted mid-operation SHALL abandon the computation; after release the block waits for start in IDLE_RQ.

Structure
REQ-023 Package fsm_rayleigh SHALL hold the state_rayleigh enum; the double type and FP operations come from fp_double.
REQ-024 One sub-module fp_mac (combinational a*b+c on double) SHALL be used; one instance for MATVEC, a second for den in DOT, the first reused for num.
REQ-025 Indices SHALL be sized $clog2(SIZE_N) with terminal-count compare, not modulo wrap.

Verification
REQ-026 SIZE_N=8, A=identity, v=[1,0,...,0], start high -> f high after edge 73, eigenvalue=1.0, zero_vec=0.
REQ-027 SIZE_N=8, A=2.0*identity, v=all 1.0 -> eigenvalue=2.0 exactly at edge 73.
REQ-028 SIZE_N=2, A=[[2,1],[1,2]], v=[1,1] -> f after edge 7, eigenvalue=3.0.
REQ-029 SIZE_N=8, v=all 0.0 -> edge 73: eigenvalue=+0.0, zero_vec=1, f=1.
REQ-030 rst=0 pulsed mid-MATVEC (edge 20) -> f=0, eigenvalue=+0.0 immediately; re-start after release gives the full 73-edge latency and correct result.
REQ-031 After f=1, hold start 10 cycles -> outputs stable; drop start -> IDLE_RQ next edge, f=0, eigenvalue retained; change vector_in mid-MATVEC -> result unchanged.

Source files
------------

// File: rtl/fp_double.sv
// IEEE-754 binary64 type and combinational arithmetic (round-to-nearest-even).
// Subnormal operands and results are flushed to zero; overflow saturates to infinity.
package fp_double;

  typedef logic [63:0] double_t;

  localparam double_t FP_ZERO  = 64'h0;
  localparam int      EXP_BIAS = 1023;

  // m[55] is the hidden bit, m[54:3] the fraction, m[2:0] guard/round/sticky.
  function automatic double_t fp_round_pack(input logic s, input int e, input logic [55:0] m);
    logic [53:0] mr;
    logic        rnd;
    int          ex;
    rnd = m[2] & (m[1] | m[0] | m[3]);
    mr  = {1'b0, m[55:3]} + {53'b0, rnd};
    ex  = mr[53] ? e + 1 : e;
    if (ex >= 2047) return {s, 11'h7FF, 52'h0};
    if (ex <= 0) return {s, 63'h0};
    return {s, ex[10:0], (mr[53] ? mr[52:1] : mr[51:0])};
  endfunction

  function automatic double_t fp_mul(input double_t a, input double_t b);
    logic         s;
    logic [105:0] p;
    int           e;
    s = a[63] ^ b[63];
    if (a[62:52] == '0 || b[62:52] == '0) return {s, 63'h0};
    p = 106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]});
    e = int'(a[62:52]) + int'(b[62:52]) - EXP_BIAS;
    if (p[105]) return fp_round_pack(s, e + 1, {p[105:51], |p[50:0]});
    return fp_round_pack(s, e, {p[104:50], |p[49:0]});
  endfunction

  function automatic double_t fp_add(input double_t a, input double_t b);
    double_t     x, y;
    logic [55:0] mx, my, sh;
    logic [56:0] sum;
    logic        found;
    int          d, e, lz;
    if (a[62:52] == '0) return (b[62:52] == '0) ? FP_ZERO : b;
    if (b[62:52] == '0) return a;
    if (a[62:0] >= b[62:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d  = int'(x[62:52]) - int'(y[62:52]);
    e  = int'(x[62:52]);
    mx = {1'b1, x[51:0], 3'b0};
    my = {1'b1, y[51:0], 3'b0};
    if (d > 55) begin
      sh = 56'd1;
    end else begin
      sh    = my >> d;
      sh[0] = sh[0] | (|(my & ~({56{1'b1}} << d)));
    end
    if (x[63] == y[63]) begin
      sum = {1'b0, mx} + {1'b0, sh};
      if (sum[56]) return fp_round_pack(x[63], e + 1, {sum[56:2], sum[1] | sum[0]});
      return fp_round_pack(x[63], e, sum[55:0]);
    end
    sum = {1'b0, mx} - {1'b0, sh};
    if (sum == '0) return FP_ZERO;
    lz    = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < 56; k++) begin
      if (!found && sum[55 - k]) begin
        lz    = int'(k);
        found = 1'b1;
      end
    end
    return fp_round_pack(x[63], e - lz, sum[55:0] << lz);
  endfunction

  function automatic double_t fp_div(input double_t a, input double_t b);
    logic         s;
    logic [108:0] n, dv;
    logic [56:0]  q;
    logic [52:0]  r;
    int           e;
    s = a[63] ^ b[63];
    if (b[62:52] == '0) return {s, 11'h7FF, 52'h0};
    if (a[62:52] == '0) return {s, 63'h0};
    n  = {1'b1, a[51:0], 56'b0};
    dv = {56'b0, 1'b1, b[51:0]};
    q  = 57'(n / dv);
    r  = 53'(n % dv);
    e  = int'(a[62:52]) - int'(b[62:52]) + EXP_BIAS;
    if (q[56]) return fp_round_pack(s, e, {q[56:2], (|q[1:0]) | (|r)});
    return fp_round_pack(s, e - 1, {q[55:1], q[0] | (|r)});
  endfunction

endpackage

// File: rtl/rayleigh_quotient_pkg.sv
// FSM state encoding for the Rayleigh quotient block.
package fsm_rayleigh;

  typedef enum logic [2:0] {
    IDLE_RQ,
    MATVEC_RQ,
    DOT_RQ,
    DIVIDE_RQ,
    FINISHED_RQ
  } state_rayleigh;

endpackage

// File: rtl/rayleigh_quotient_fp_mac.sv
// Combinational double-precision multiply-accumulate: y = a*b + c.
module fp_mac
  import fp_double::*;
(
  input  double_t a,
  input  double_t b,
  input  double_t c,
  output double_t y
);

  assign y = fp_add(fp_mul(a, b), c);

endmodule

// File: rtl/rayleigh_quotient.sv
// Rayleigh quotient lambda = (v^T A v)/(v^T v) of a latched matrix/vector pair,
// computed with one MAC per cycle for A*v, then two MACs per cycle for the dot products.
module rayleigh_quotient
  import fp_double::*;
  import fsm_rayleigh::*;
#(
  parameter int SIZE_N = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    start,
  input  double_t timed_matrix [SIZE_N][SIZE_N],
  input  double_t vector_in    [SIZE_N][1],
  output double_t eigenvalue,
  output logic    zero_vec,
  output logic    f
);

  localparam int            IW   = $clog2(SIZE_N);
  localparam logic [IW-1:0] LAST = IW'(SIZE_N - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  state_rayleigh state, state_nx;

  double_t       a_r [SIZE_N][SIZE_N];
  double_t       v_r [SIZE_N];
  double_t       w   [SIZE_N];
  double_t       num, den;
  logic [IW-1:0] i_idx, j_idx;
  double_t       mac0_a, mac0_b, mac0_c, mac0_y, mac1_y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE_RQ;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = IDLE_RQ;
    f        = 1'b0;
    case (state)
      IDLE_RQ:     state_nx = start ? MATVEC_RQ : IDLE_RQ;
      MATVEC_RQ:   state_nx = (i_idx == LAST && j_idx == LAST) ? DOT_RQ : MATVEC_RQ;
      DOT_RQ:      state_nx = (i_idx == LAST) ? DIVIDE_RQ : DOT_RQ;
      DIVIDE_RQ:   state_nx = FINISHED_RQ;
      FINISHED_RQ: begin
        f        = 1'b1;
        state_nx = start ? FINISHED_RQ : IDLE_RQ;
      end
      default:     state_nx = IDLE_RQ;
    endcase
  end

  // The matvec MAC is reused for the numerator dot product during DOT_RQ.
  always_comb begin
    mac0_a = a_r[i_idx][j_idx];
    mac0_b = v_r[j_idx];
    mac0_c = w[i_idx];
    if (state == DOT_RQ) begin
      mac0_a = v_r[i_idx];
      mac0_b = w[i_idx];
      mac0_c = num;
    end
  end

  fp_mac u_mac_num (.a(mac0_a), .b(mac0_b), .c(mac0_c), .y(mac0_y));
  fp_mac u_mac_den (.a(v_r[i_idx]), .b(v_r[i_idx]), .c(den), .y(mac1_y));

  always_ff @(posedge clk) begin
    if (state == IDLE_RQ && start) begin
      for (int unsigned r = 0; r < SIZE_N; r++) begin
        v_r[r] <= vector_in[r][0];
        for (int unsigned c = 0; c < SIZE_N; c++) a_r[r][c] <= timed_matrix[r][c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < SIZE_N; k++) w[k] <= FP_ZERO;
      num        <= FP_ZERO;
      den        <= FP_ZERO;
      i_idx      <= '0;
      j_idx      <= '0;
      eigenvalue <= FP_ZERO;
      zero_vec   <= 1'b0;
    end else begin
      case (state)
        IDLE_RQ: begin
          if (start) begin
            for (int unsigned k = 0; k < SIZE_N; k++) w[k] <= FP_ZERO;
            num   <= FP_ZERO;
            den   <= FP_ZERO;
            i_idx <= '0;
            j_idx <= '0;
          end
        end
        MATVEC_RQ: begin
          w[i_idx] <= mac0_y;
          if (j_idx == LAST) begin
            j_idx <= '0;
            i_idx <= (i_idx == LAST) ? '0 : i_idx + ONE;
          end else begin
            j_idx <= j_idx + ONE;
          end
        end
        DOT_RQ: begin
          num   <= mac0_y;
          den   <= mac1_y;
          i_idx <= (i_idx == LAST) ? '0 : i_idx + ONE;
        end
        DIVIDE_RQ: begin
          // Sign of den is ignored: -0.0 also counts as a zero vector.
          if (den[62:0] == '0) begin
            eigenvalue <= FP_ZERO;
            zero_vec   <= 1'b1;
          end else begin
            eigenvalue <= fp_div(num, den);
            zero_vec   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
